// File: rtl/boid_frame_scheduler_if.sv
// Display-RAM write port plus BPU mux select/address, bundled for the frame scheduler.
// Ports: boid_select/boid_address (BPU mux), ram_switch/ram_we/ram_write_addr (display RAM).
// master = scheduler side, slave = RAM/BPU side. Widths must match the scheduler's parameters.
interface boid_frame_scheduler_if #(
  parameter int BOID_IDX_WIDTH = 3,
  parameter int ADDR_WIDTH     = 20
);
  logic [BOID_IDX_WIDTH-1:0] boid_select;
  logic [ADDR_WIDTH-1:0]     boid_address;
  logic                      ram_switch;
  logic                      ram_we;
  logic [ADDR_WIDTH-1:0]     ram_write_addr;

  modport master (
    output boid_select, ram_switch, ram_we, ram_write_addr,
    input  boid_address
  );

  modport slave (
    input  boid_select, ram_switch, ram_we, ram_write_addr,
    output boid_address
  );
endinterface

// File: rtl/boid_frame_scheduler.sv
// Per-frame display-RAM update sequencer: on a screen_end rising edge, one switch pulse then one write per boid.
// Latency: n+2 cycles from the detected edge to frame_done (n = min(num_boids, MAX_BOIDS)).
// No backpressure: one boid per cycle; edges arriving while busy are dropped and flagged in overrun.
// Ports: clock/reset, screen_end, num_boids, bus (BPU mux + RAM write), busy, frame_done, overrun, frame_count.
module boid_frame_scheduler #(
  parameter int MAX_BOIDS       = 8,
  parameter int BOID_IDX_WIDTH  = 3,
  parameter int PIXEL_COUNT     = 307200,
  parameter int ADDR_WIDTH      = 20,
  parameter int FRAME_CNT_WIDTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       screen_end,
  input  logic [BOID_IDX_WIDTH:0]    num_boids,
  boid_frame_scheduler_if.master     bus,
  output logic                       busy,
  output logic                       frame_done,
  output logic                       overrun,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SWITCH = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  localparam logic [BOID_IDX_WIDTH:0]    MAX_CNT = (BOID_IDX_WIDTH+1)'(MAX_BOIDS);
  localparam logic [BOID_IDX_WIDTH:0]    CNT_ONE = (BOID_IDX_WIDTH+1)'(1);
  localparam logic [BOID_IDX_WIDTH-1:0]  IDX_ONE = BOID_IDX_WIDTH'(1);
  localparam logic [FRAME_CNT_WIDTH-1:0] FC_ONE  = FRAME_CNT_WIDTH'(1);
  // One extra bit so a PIXEL_COUNT equal to 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]        PIX_LIM = (ADDR_WIDTH+1)'(PIXEL_COUNT);

  logic [1:0]                state;
  logic [BOID_IDX_WIDTH-1:0] idx;
  logic [BOID_IDX_WIDTH:0]   n;
  logic                      se_prev;
  logic                      rise;
  logic                      in_write;

  assign rise     = screen_end & ~se_prev;
  assign in_write = (state == WRITE);

  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  assign bus.ram_switch     = (state == SWITCH);
  assign bus.boid_select    = in_write ? idx : '0;
  assign bus.ram_write_addr = in_write ? bus.boid_address : '0;
  // Off-screen boids still take their cycle; only the write strobe is suppressed.
  assign bus.ram_we         = in_write && ({1'b0, bus.boid_address} < PIX_LIM);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      idx         <= '0;
      n           <= '0;
      // Held at 1 so a screen_end already high at reset release is not seen as an edge.
      se_prev     <= 1'b1;
      overrun     <= 1'b0;
      frame_count <= '0;
    end else begin
      se_prev <= screen_end;
      if (rise && state != IDLE) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (rise) begin
            n     <= (num_boids > MAX_CNT) ? MAX_CNT : num_boids;
            state <= SWITCH;
          end
        end
        SWITCH: begin
          idx   <= '0;
          state <= (n != '0) ? WRITE : DONE;
        end
        WRITE: begin
          if ({1'b0, idx} == n - CNT_ONE) state <= DONE;
          else                            idx   <= idx + IDX_ONE;
        end
        DONE: begin
          frame_count <= frame_count + FC_ONE;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_boid_frame_scheduler.sv
// Bench for boid_frame_scheduler: frame-level vector table, hand-written corner sequences,
// and a randomized run, all checked every cycle against a timeline-based reference model.
module tb_boid_frame_scheduler;

  localparam int PIXEL_COUNT = 307200;

  logic        clock;
  logic        reset;
  logic        screen_end;
  logic [3:0]  num_boids;
  logic        busy;
  logic        frame_done;
  logic        overrun;
  logic [15:0] frame_count;

  boid_frame_scheduler_if #(.BOID_IDX_WIDTH(3), .ADDR_WIDTH(20)) bus ();

  boid_frame_scheduler dut (
    .clock       (clock),
    .reset       (reset),
    .screen_end  (screen_end),
    .num_boids   (num_boids),
    .bus         (bus.master),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural BPU mux: address of the selected boid.
  logic [19:0] addr_tab [8];
  always_comb bus.boid_address = addr_tab[bus.boid_select];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a frame is a timeline anchored at the edge cycle m_c.
  bit m_active = 0;
  int m_c      = 0;
  int m_n      = 0;
  bit m_prev   = 1;
  bit m_ovr    = 0;
  int m_fc     = 0;

  // Last sampled DUT outputs, for the frame-level checks.
  logic s_we, s_sw, s_done, s_busy, s_ovr;
  logic [15:0] s_fc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic step(input logic se, input logic rst, input logic [3:0] nb);
    int off;
    bit e_sw, e_we, e_busy, e_done, rise;
    int e_sel;
    logic [19:0] e_addr;
    screen_end = se;
    reset      = rst;
    num_boids  = nb;
    @(negedge clock);
    e_sw = 0; e_we = 0; e_busy = 0; e_done = 0; e_sel = 0; e_addr = '0;
    if (m_active) begin
      off = cyc - m_c;
      e_busy = (off >= 1 && off <= m_n + 2);
      e_sw   = (off == 1);
      e_done = (off == m_n + 2);
      if (off >= 2 && off <= m_n + 1) begin
        e_sel  = off - 2;
        e_addr = addr_tab[off-2];
        e_we   = (int'(addr_tab[off-2]) < PIXEL_COUNT);
      end
    end
    chk("ram_switch",     32'(bus.ram_switch),     32'(e_sw));
    chk("ram_we",         32'(bus.ram_we),         32'(e_we));
    chk("ram_write_addr", 32'(bus.ram_write_addr), 32'(e_addr));
    chk("boid_select",    32'(bus.boid_select),    32'(e_sel));
    chk("busy",           32'(busy),               32'(e_busy));
    chk("frame_done",     32'(frame_done),         32'(e_done));
    chk("overrun",        32'(overrun),            32'(m_ovr));
    chk("frame_count",    32'(frame_count),        32'(m_fc));
    s_we = bus.ram_we; s_sw = bus.ram_switch; s_done = frame_done;
    s_busy = busy; s_ovr = overrun; s_fc = frame_count;
    if (rst) begin
      m_active = 0; m_prev = 1; m_ovr = 0; m_fc = 0;
    end else begin
      rise = se && !m_prev;
      if (e_done) begin
        m_fc = (m_fc + 1) % 65536;
        m_active = 0;
      end
      if (rise) begin
        if (e_busy) m_ovr = 1;
        else begin
          m_active = 1;
          m_c = cyc;
          m_n = (nb > 8) ? 8 : int'(nb);
        end
      end
      m_prev = se;
    end
    @(posedge clock);
    cyc++;
    #1;
  endtask

  typedef struct {
    logic [3:0] nb;
    bit         bad_addr;
    int         exp_writes;
    int         exp_done_off;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int writes, sws, done_off, dones;

    vecs[0] = '{4'd8,  1'b0, 8, 10};
    vecs[1] = '{4'd3,  1'b0, 3, 5};
    vecs[2] = '{4'd0,  1'b0, 0, 2};
    vecs[3] = '{4'd15, 1'b0, 8, 10};
    vecs[4] = '{4'd8,  1'b1, 6, 10};
    vecs[5] = '{4'd1,  1'b0, 1, 3};

    for (int i = 0; i < 8; i++) addr_tab[i] = 20'(i * 641);

    // Reset with screen_end held high through release: no frame may start.
    reset = 1'b1; screen_end = 1'b1; num_boids = 4'd8;
    repeat (2) @(posedge clock);
    #1;
    step(1, 1, 8);
    step(1, 1, 8);
    repeat (6) step(1, 0, 8);
    chk("no_start_after_reset", 32'(s_busy), 32'd0);
    repeat (3) step(0, 0, 8);

    // Frame-level vector table.
    foreach (vecs[r]) begin
      for (int i = 0; i < 8; i++) addr_tab[i] = 20'(i * 641);
      if (vecs[r].bad_addr) begin
        addr_tab[2] = 20'd307200;
        addr_tab[5] = 20'hFFFFF;
      end
      step(1, 0, vecs[r].nb);
      writes = 0; sws = 0; done_off = -1;
      for (int k = 1; k <= 30 && done_off < 0; k++) begin
        step(0, 0, vecs[r].nb);
        if (s_we) writes++;
        if (s_sw) sws++;
        if (s_done) done_off = k;
      end
      chk("row_writes",  32'(writes),   32'(vecs[r].exp_writes));
      chk("row_latency", 32'(done_off), 32'(vecs[r].exp_done_off));
      chk("row_switch",  32'(sws),      32'd1);
      repeat (2) step(0, 0, vecs[r].nb);
    end
    for (int i = 0; i < 8; i++) addr_tab[i] = 20'(i * 641);

    // Overrun: second edge 4 cycles after the first is dropped, flag sticks.
    step(0, 1, 8);
    step(0, 1, 8);
    step(0, 0, 8);
    step(1, 0, 8);
    repeat (3) step(0, 0, 8);
    step(1, 0, 8);
    done_off = -1;
    for (int k = 5; k <= 30 && done_off < 0; k++) begin
      step(0, 0, 8);
      if (s_done) done_off = k;
    end
    chk("overrun_latency", 32'(done_off), 32'd10);
    step(0, 0, 8);
    chk("overrun_sticky", 32'(s_ovr), 32'd1);
    step(1, 0, 8);
    repeat (14) step(0, 0, 8);
    chk("overrun_frame_count", 32'(s_fc), 32'd2);
    chk("overrun_still_set",   32'(s_ovr), 32'd1);

    // screen_end held high for 20 cycles: exactly one frame.
    dones = 0;
    for (int k = 0; k < 20; k++) begin
      step(1, 0, 4);
      if (s_done) dones++;
    end
    repeat (5) begin
      step(0, 0, 4);
      if (s_done) dones++;
    end
    chk("held_high_frames", 32'(dones), 32'd1);

    // Reset during the 4th write cycle abandons the frame.
    step(1, 0, 8);
    repeat (4) step(0, 0, 8);
    step(0, 1, 8);
    chk("write4_seen", 32'(s_we), 32'd1);
    step(0, 0, 8);
    chk("post_reset_we",   32'(s_we),   32'd0);
    chk("post_reset_busy", 32'(s_busy), 32'd0);
    dones = 0;
    repeat (12) begin
      step(0, 0, 8);
      if (s_done) dones++;
    end
    chk("abandoned_no_done", 32'(dones), 32'd0);

    // Randomized run: all checking by the per-cycle model.
    begin
      logic se_r;
      se_r = 1'b0;
      for (int k = 0; k < 600; k++) begin
        if (k % 50 == 0) begin
          for (int i = 0; i < 8; i++)
            addr_tab[i] = ($urandom_range(0, 9) == 0) ? 20'hFFFFF
                                                      : 20'($urandom_range(0, 360000));
        end
        if ($urandom_range(0, 3) == 0) se_r = ~se_r;
        step(se_r, ($urandom_range(0, 149) == 0), 4'($urandom_range(0, 15)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
